// File: rtl/dm_bytelane.sv
// dm_bytelane: byte-addressed data memory for the MIPS core.
// Word storage with sub-word loads/stores, a registered read port with a
// one-cycle valid strobe, misalignment flagging and a hardware clear sweep
// that runs after reset or on request while busy is high.

module dm_bytelane #(
  parameter int ADDR_W   = 12,
  parameter bit TRACE_EN = 1'b1
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              clr_req,
  input  logic              mem_we,
  input  logic              mem_re,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [31:0]       pc,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              misalign,
  output logic              busy
);

  localparam int IW    = ADDR_W - 2;
  localparam int DEPTH = 2 ** IW;
  localparam logic [IW-1:0] PTR_LAST = '1;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  state_t      state;
  logic [IW-1:0] ptr;
  logic [31:0] mem [0:DEPTH-1];

  logic [IW-1:0] idx;
  logic [1:0]  lane;
  logic        is_word;
  logic        is_half;
  logic        is_byte;
  logic        mis;
  logic [3:0]  be;
  logic [31:0] wlanes;
  logic [31:0] cur_word;
  logic [31:0] merged;
  logic [15:0] sel_half;
  logic [7:0]  sel_byte;
  logic [31:0] load_val;
  logic        do_store;
  logic [31:0] trace_addr;

  assign idx  = addr[ADDR_W-1:2];
  assign lane = addr[1:0];

  // A store only commits when the memory is idle, no clear is requested and
  // the address is aligned for the access size.
  assign do_store = (state == ST_IDLE) && !clr_req && mem_we && !mis;

  // Byte address of the touched word, widened for the trace print.
  assign trace_addr = {{(32 - ADDR_W){1'b0}}, addr[ADDR_W-1:2], 2'b00};

  // Decode access size, alignment, store lane merge and extended load value.
  always_comb begin
    is_word = 1'b0;
    is_half = 1'b0;
    is_byte = 1'b0;
    case (op)
      3'b001, 3'b010: is_half = 1'b1;
      3'b011, 3'b100: is_byte = 1'b1;
      default:        is_word = 1'b1;
    endcase

    mis = (is_word && (lane != 2'b00)) || (is_half && lane[0]);

    be     = 4'b0000;
    wlanes = 32'h0;
    if (is_word) begin
      be     = 4'b1111;
      wlanes = wdata;
    end else if (is_half) begin
      be     = lane[1] ? 4'b1100 : 4'b0011;
      wlanes = {2{wdata[15:0]}};
    end else begin
      be     = 4'b0001 << lane;
      wlanes = {4{wdata[7:0]}};
    end

    cur_word = mem[idx];
    merged   = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = wlanes[8*i +: 8];
      end
    end

    sel_half = lane[1] ? cur_word[31:16] : cur_word[15:0];
    case (lane)
      2'd0:    sel_byte = cur_word[7:0];
      2'd1:    sel_byte = cur_word[15:8];
      2'd2:    sel_byte = cur_word[23:16];
      default: sel_byte = cur_word[31:24];
    endcase

    case (op)
      3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
      3'b010:  load_val = {16'h0, sel_half};
      3'b011:  load_val = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  load_val = {24'h0, sel_byte};
      default: load_val = cur_word;
    endcase
  end

  // Storage array: zeroed one word per cycle by the sweep, otherwise
  // updated with the merged word of a committed store.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[ptr] <= 32'h0;
    end else if (do_store) begin
      mem[idx] <= merged;
    end
  end

  // Control FSM: clear sweep sequencing plus the registered read port.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= ST_CLEAR;
      ptr      <= '0;
      rdata    <= 32'h0;
      rvalid   <= 1'b0;
      misalign <= 1'b0;
      busy     <= 1'b1;
    end else begin
      rvalid <= 1'b0;
      case (state)
        ST_CLEAR: begin
          if (clr_req) begin
            ptr <= '0;
          end else if (ptr == PTR_LAST) begin
            ptr   <= '0;
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          if (clr_req) begin
            state <= ST_CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
          end else if (mem_we) begin
            if (mis) begin
              rvalid   <= 1'b1;
              misalign <= 1'b1;
            end else begin
              misalign <= 1'b0;
            end
          end else if (mem_re) begin
            rvalid   <= 1'b1;
            misalign <= mis;
            rdata    <= mis ? 32'h0 : load_val;
          end
        end
      endcase
    end
  end

  generate
    if (TRACE_EN) begin : g_trace
      // Print one line per committed store showing the merged word.
      always_ff @(posedge clk) begin
        if (do_store) begin
          $display("@%h: *%h <= %h", pc, trace_addr, merged);
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_dm_bytelane.sv
// Testbench for dm_bytelane: byte-level reference memory, expected load
// responses queued at issue time and popped by an rvalid-driven monitor.

module tb_dm_bytelane;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 1024;
  localparam int NBYTES = 4 * DEPTH;

  logic              clk = 1'b0;
  logic              clr_n;
  logic              clr_req;
  logic              mem_we;
  logic              mem_re;
  logic [2:0]        op;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       pc;
  logic [31:0]       rdata;
  logic              rvalid;
  logic              misalign;
  logic              busy;

  int errors = 0;
  int checks = 0;

  logic [32:0] exp_q [$];
  logic [7:0]  ref_mem [0:NBYTES-1];
  logic [31:0] last_rdata;

  dm_bytelane #(.ADDR_W(ADDR_W), .TRACE_EN(1'b1)) dut (
    .clk(clk), .clr_n(clr_n), .clr_req(clr_req), .mem_we(mem_we),
    .mem_re(mem_re), .op(op), .addr(addr), .wdata(wdata), .pc(pc),
    .rdata(rdata), .rvalid(rvalid), .misalign(misalign), .busy(busy)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic ref_clear_mem();
    for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
  endtask

  // Every rvalid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (clr_n === 1'b1 && rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rvalid: got rvalid=1 rdata=%h, expected no response", rdata);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check_output("load_rdata", rdata, e[31:0]);
        check_output("load_misalign", {31'b0, misalign}, {31'b0, e[32]});
      end
    end
  end

  // Issue one access for one cycle; the reference computes its outcome.
  task automatic apply_stimulus(input logic we, input logic re, input logic [2:0] o,
                                input logic [ADDR_W-1:0] a, input logic [31:0] wd);
    int          size;
    logic        mis;
    logic [31:0] v;
    mem_we  = we;
    mem_re  = re;
    op      = o;
    addr    = a;
    wdata   = wd;
    clr_req = 1'b0;
    pc      = $urandom;
    size = (o == 3'd1 || o == 3'd2) ? 2 : ((o == 3'd3 || o == 3'd4) ? 1 : 4);
    mis  = (size == 4 && a[1:0] != 2'b00) || (size == 2 && a[0]);
    if (we) begin
      if (mis) exp_q.push_back({1'b1, last_rdata});
      else for (int k = 0; k < size; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
    end else if (re) begin
      if (mis) begin
        last_rdata = 32'h0;
      end else begin
        v = 32'h0;
        for (int k = 0; k < size; k++) v[8*k +: 8] = ref_mem[int'(a) + k];
        if (o == 3'd1) v = {{16{v[15]}}, v[15:0]};
        if (o == 3'd3) v = {{24{v[7]}}, v[7:0]};
        last_rdata = v;
      end
      exp_q.push_back({mis, last_rdata});
    end
    @(posedge clk);
    #1;
    mem_we = 1'b0;
    mem_re = 1'b0;
    if (we && !mis) begin
      check_output("store_no_rvalid", {31'b0, rvalid}, 32'd0);
      check_output("store_misalign", {31'b0, misalign}, 32'd0);
    end
  endtask

  // Count cycles until busy drops, optionally firing loads that must be ignored.
  task automatic measure_busy(input string name, input bit loads);
    int n;
    int rv_seen;
    n = 0;
    rv_seen = 0;
    while (busy === 1'b1 && n < 4000) begin
      if (loads) begin
        mem_re = 1'b1;
        op     = 3'd0;
        addr   = ADDR_W'($urandom_range(0, NBYTES - 1)) & ~ADDR_W'(3);
      end
      @(posedge clk);
      #1;
      n++;
      if (rvalid === 1'b1) rv_seen++;
    end
    mem_re = 1'b0;
    check_output(name, n, DEPTH);
    if (loads) check_output("no_rvalid_while_busy", rv_seen, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    clr_n = 1'b0; clr_req = 1'b0; mem_we = 1'b0; mem_re = 1'b0;
    op = 3'd0; addr = '0; wdata = 32'h0; pc = 32'h0;
    ref_clear_mem();
    last_rdata = 32'h0;

    #12;
    check_output("reset_rdata", rdata, 32'h0);
    check_output("reset_rvalid", {31'b0, rvalid}, 32'd0);
    check_output("reset_misalign", {31'b0, misalign}, 32'd0);
    check_output("reset_busy", {31'b0, busy}, 32'd1);

    @(posedge clk);
    #1;
    clr_n = 1'b1;
    measure_busy("busy_after_reset", 1'b1);

    apply_stimulus(1'b0, 1'b1, 3'd0, 12'h000, 32'h0);
    apply_stimulus(1'b0, 1'b1, 3'd0, 12'hFFC, 32'h0);

    apply_stimulus(1'b1, 1'b0, 3'd0, 12'h010, 32'h12345678);
    apply_stimulus(1'b1, 1'b0, 3'd3, 12'h011, 32'h000000AB);
    apply_stimulus(1'b0, 1'b1, 3'd0, 12'h010, 32'h0);

    apply_stimulus(1'b1, 1'b0, 3'd0, 12'h020, 32'h8000FF80);
    apply_stimulus(1'b0, 1'b1, 3'd3, 12'h020, 32'h0);
    apply_stimulus(1'b0, 1'b1, 3'd4, 12'h020, 32'h0);
    apply_stimulus(1'b0, 1'b1, 3'd1, 12'h022, 32'h0);
    apply_stimulus(1'b0, 1'b1, 3'd2, 12'h022, 32'h0);

    apply_stimulus(1'b1, 1'b0, 3'd0, 12'h030, 32'hCAFEF00D);
    apply_stimulus(1'b1, 1'b0, 3'd0, 12'h031, 32'h11111111);
    apply_stimulus(1'b0, 1'b1, 3'd0, 12'h030, 32'h0);
    apply_stimulus(1'b0, 1'b1, 3'd1, 12'h033, 32'h0);

    apply_stimulus(1'b1, 1'b0, 3'd2, 12'h052, 32'h0000BEEF);
    apply_stimulus(1'b1, 1'b0, 3'd4, 12'h051, 32'h00000077);
    apply_stimulus(1'b0, 1'b1, 3'd0, 12'h050, 32'h0);
    apply_stimulus(1'b1, 1'b1, 3'd0, 12'h054, 32'hA5A5A5A5);
    apply_stimulus(1'b0, 1'b1, 3'd0, 12'h054, 32'h0);

    for (int i = 0; i < 400; i++) begin
      logic              we;
      logic              re;
      logic [ADDR_W-1:0] a;
      we = ($urandom_range(0, 2) == 0);
      re = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 7) == 0) a = ADDR_W'($urandom_range(NBYTES - 64, NBYTES - 1));
      else a = ADDR_W'($urandom_range(0, 127));
      apply_stimulus(we, re, 3'($urandom_range(0, 4)), a, $urandom);
    end

    apply_stimulus(1'b1, 1'b0, 3'd0, 12'h040, 32'hDEADBEEF);
    apply_stimulus(1'b0, 1'b1, 3'd0, 12'h040, 32'h0);
    clr_req = 1'b1; mem_we = 1'b1; mem_re = 1'b1; op = 3'd0; addr = 12'h044; wdata = 32'h11111111;
    @(posedge clk);
    #1;
    clr_req = 1'b0; mem_we = 1'b0; mem_re = 1'b0;
    ref_clear_mem();
    check_output("busy_after_clr_req", {31'b0, busy}, 32'd1);
    measure_busy("busy_after_clr_req_len", 1'b0);
    apply_stimulus(1'b0, 1'b1, 3'd0, 12'h040, 32'h0);
    apply_stimulus(1'b0, 1'b1, 3'd0, 12'h044, 32'h0);

    apply_stimulus(1'b1, 1'b0, 3'd0, 12'h080, 32'h55AA1234);
    apply_stimulus(1'b0, 1'b1, 3'd0, 12'h080, 32'h0);
    apply_stimulus(1'b1, 1'b0, 3'd0, 12'h081, 32'h0);
    @(posedge clk);
    #1;
    clr_req = 1'b1;
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    ref_clear_mem();
    repeat (499) @(posedge clk);
    #3;
    clr_n = 1'b0;
    #1;
    check_output("midsweep_rdata", rdata, 32'h0);
    check_output("midsweep_rvalid", {31'b0, rvalid}, 32'd0);
    check_output("midsweep_misalign", {31'b0, misalign}, 32'd0);
    check_output("midsweep_busy", {31'b0, busy}, 32'd1);
    last_rdata = 32'h0;
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    measure_busy("busy_after_midsweep_reset", 1'b0);
    apply_stimulus(1'b0, 1'b1, 3'd0, 12'h080, 32'h0);
    apply_stimulus(1'b0, 1'b1, 3'd0, 12'hFFC, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    check_output("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
